// File: rtl/mips_pkg.sv
// Shared MIPS control encodings: opcodes, function codes, ALUOp and ALU_ctrl values,
// plus the payload carried by the main-decoder control register bank.
package mips_pkg;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned ALUCTL_W = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] F_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] F_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] F_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] F_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] F_SLT = 6'b101010;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic reg_write;
        logic reg_dst;
        logic alu_src;
        logic branch;
        logic mem_write;
        logic mem_to_reg;
        logic jump;
    } main_ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: ALUOp plus R-type Funct to ALU operation select.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_c
);

    always_comb begin
        alu_ctrl_c = ALU_ADD;
        case (aluop_i)
            ALUOP_ADD:  alu_ctrl_c = ALU_ADD;
            ALUOP_SUB:  alu_ctrl_c = ALU_SUB;
            ALUOP_RSVD: alu_ctrl_c = ALU_ADD;
            ALUOP_FUNCT: begin
                // Unknown function codes fall back to add
                case (funct_i)
                    F_ADD:   alu_ctrl_c = ALU_ADD;
                    F_SUB:   alu_ctrl_c = ALU_SUB;
                    F_AND:   alu_ctrl_c = ALU_AND;
                    F_OR:    alu_ctrl_c = ALU_OR;
                    F_SLT:   alu_ctrl_c = ALU_SLT;
                    default: alu_ctrl_c = ALU_ADD;
                endcase
            end
            default: alu_ctrl_c = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/controller.sv
// Single-cycle MIPS main control unit: opcode decode plus ALU decode, with all
// control outputs registered and cleared by a synchronous active-low reset.
module controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] Funct,
    output logic       MemtoReg,
    output logic       MemWrite,
    output logic       Branch,
    output logic       ALUSrc,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       Jump,
    output logic [2:0] ALU_ctrl
);

    main_ctrl_t    ctrl_d;
    main_ctrl_t    ctrl_q;
    logic [1:0]    aluop_c;
    logic [2:0]    alu_ctrl_c;
    logic [2:0]    alu_ctrl_q;

    // Main decoder; unlisted opcodes leave every control deasserted
    always_comb begin
        ctrl_d  = '0;
        aluop_c = ALUOP_ADD;
        case (op)
            OP_RTYPE: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = 1'b1;
                aluop_c          = ALUOP_FUNCT;
            end
            OP_LW: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl_d.branch = 1'b1;
                aluop_c       = ALUOP_SUB;
            end
            OP_ADDI: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
            end
            OP_J: begin
                ctrl_d.jump = 1'b1;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop_i    (aluop_c),
        .funct_i    (Funct),
        .alu_ctrl_c (alu_ctrl_c)
    );

    // Output register bank; reset wins over decode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            alu_ctrl_q <= ALU_AND;
        end else begin
            ctrl_q     <= ctrl_d;
            alu_ctrl_q <= alu_ctrl_c;
        end
    end

    assign RegWrite = ctrl_q.reg_write;
    assign RegDst   = ctrl_q.reg_dst;
    assign ALUSrc   = ctrl_q.alu_src;
    assign Branch   = ctrl_q.branch;
    assign MemWrite = ctrl_q.mem_write;
    assign MemtoReg = ctrl_q.mem_to_reg;
    assign Jump     = ctrl_q.jump;
    assign ALU_ctrl = alu_ctrl_q;

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: directed test-plan cases followed by
// randomized op/Funct/reset traffic compared against a table-driven reference model.
module tb_controller;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] Funct;
    logic       MemtoReg, MemWrite, Branch, ALUSrc, RegDst, RegWrite, Jump;
    logic [2:0] ALU_ctrl;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [9:0] got;
    logic [9:0] exp_v;

    // Reference tables: opcode -> {RegWrite,RegDst,ALUSrc,Branch,MemWrite,MemtoReg,Jump}
    logic [6:0] ctl_tbl [logic [5:0]];
    logic [2:0] funct_tbl [logic [5:0]];
    logic [5:0] op_list [6];
    logic [5:0] funct_list [5];

    controller dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op       (op),
        .Funct    (Funct),
        .MemtoReg (MemtoReg),
        .MemWrite (MemWrite),
        .Branch   (Branch),
        .ALUSrc   (ALUSrc),
        .RegDst   (RegDst),
        .RegWrite (RegWrite),
        .Jump     (Jump),
        .ALU_ctrl (ALU_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign got = {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, Jump, ALU_ctrl};

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, expv);
        end
    endtask

    // Expected registered outputs for a given reset/op/Funct sampled at an edge
    function automatic logic [9:0] model(input logic r, input logic [5:0] o, input logic [5:0] f);
        logic [6:0] c;
        logic [2:0] a;
        if (!r) return 10'd0;
        c = ctl_tbl.exists(o) ? ctl_tbl[o] : 7'd0;
        if (o == 6'b000000)
            a = funct_tbl.exists(f) ? funct_tbl[f] : 3'b010;
        else if (o == 6'b000100)
            a = 3'b110;
        else
            a = 3'b010;
        return {c, a};
    endfunction

    task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f);
        @(negedge clk);
        rst_n = r;
        op    = o;
        Funct = f;
        exp_v = model(r, o, f);
        @(posedge clk);
        #1;
    endtask

    initial begin
        ctl_tbl[6'b000000] = 7'b1100000;
        ctl_tbl[6'b100011] = 7'b1010010;
        ctl_tbl[6'b101011] = 7'b0010100;
        ctl_tbl[6'b000100] = 7'b0001000;
        ctl_tbl[6'b001000] = 7'b1010000;
        ctl_tbl[6'b000010] = 7'b0000001;
        funct_tbl[6'b100000] = 3'b010;
        funct_tbl[6'b100010] = 3'b110;
        funct_tbl[6'b100100] = 3'b000;
        funct_tbl[6'b100101] = 3'b001;
        funct_tbl[6'b101010] = 3'b111;
        op_list    = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        funct_list = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        rst_n = 1'b0;
        op    = 6'b100011;
        Funct = 6'b100000;

        // Reset held for two edges with lw on the bus
        step(1'b0, 6'b100011, 6'b100000);
        check("reset_edge1", got, 10'd0);
        step(1'b0, 6'b100011, 6'b100000);
        check("reset_edge2", got, 10'd0);
        step(1'b1, 6'b100011, 6'b100000);
        check("release_lw", got, 10'b1010010_010);

        step(1'b1, 6'b000000, 6'b100000);
        check("rtype_add", got, 10'b1100000_010);
        step(1'b1, 6'b100011, 6'b100000);
        check("lw", got, 10'b1010010_010);
        step(1'b1, 6'b000000, 6'b100100);
        check("rtype_and", got, 10'b1100000_000);
        step(1'b1, 6'b101011, 6'b000000);
        check("sw", got, 10'b0010100_010);
        step(1'b1, 6'b000100, 6'b000000);
        check("beq", got, 10'b0001000_110);
        step(1'b1, 6'b000010, 6'b000000);
        check("j", got, 10'b0000001_010);
        step(1'b1, 6'b000000, 6'b100010);
        check("rtype_sub", got, 10'b1100000_110);
        step(1'b1, 6'b000000, 6'b100101);
        check("rtype_or", got, 10'b1100000_001);
        step(1'b1, 6'b000000, 6'b101010);
        check("rtype_slt", got, 10'b1100000_111);
        step(1'b1, 6'b000000, 6'b111111);
        check("rtype_unknown_funct", got, 10'b1100000_010);
        step(1'b1, 6'b001000, 6'b100010);
        check("addi_funct_ignored", got, 10'b1010000_010);
        step(1'b1, 6'b111111, 6'b100010);
        check("undefined_op", got, 10'b0000000_010);
        step(1'b0, 6'b000000, 6'b101010);
        check("reset_priority", got, 10'd0);

        // Randomized traffic, including inputs wiggling between edges
        for (int i = 0; i < 400; i++) begin
            logic       r;
            logic [5:0] o;
            logic [5:0] f;
            r = ($urandom_range(0, 15) != 0);
            o = ($urandom_range(0, 7) < 6) ? op_list[$urandom_range(0, 5)] : 6'($urandom);
            f = ($urandom_range(0, 3) != 0) ? funct_list[$urandom_range(0, 4)] : 6'($urandom);
            step(r, o, f);
            check("random", got, exp_v);
            #1;
            op    = 6'($urandom);
            Funct = 6'($urandom);
            rst_n = 1'($urandom);
            @(negedge clk);
            check("hold_between_edges", got, exp_v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
